// File: rtl/lsu_subword_rmw_if.sv
// Request/response handshake between the MEM stage and the load/store unit.
// The MEM stage drives the request side through the master modport.
// The load/store unit answers through the slave modport.
interface lsu_subword_rmw_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid,
        output req_we,
        output req_funct3,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output busy
    );
endinterface

// File: rtl/lsu_subword_rmw.sv
// Load/store unit that adds RV32I byte and halfword access on top of a
// word-only data memory. The memory has a synchronous write and a
// combinational read.
//
// Loads select the addressed lane of the read word and then sign- or
// zero-extend it. SB/SH cannot write a partial word, so they read the word
// in the accept cycle, merge in the new lane, and write the full word back
// in the following cycle.
//
// Misaligned, out-of-range and illegal-funct3 requests never touch memory.
// They complete with resp_err set.
module lsu_subword_rmw #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    lsu_subword_rmw_if.slave    bus,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                mem_we,
    input  logic [31:0]         mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RMW_WR = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    logic [1:0]  state;
    logic [1:0]  state_nxt;

    // Word index and merged word carried from the SB/SH read cycle into the write cycle
    logic [29:0] rmw_idx;
    logic [31:0] merge_word;

    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic [2:0]  f3;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        f3_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        do_sw;
    logic        do_subword_store;

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [31:0] merge_nxt;

    assign accept = bus.req_valid && bus.req_ready;
    assign f3     = bus.req_funct3;

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = (state != ST_IDLE);

    // Classify the incoming request: access size, legality, alignment and range
    always_comb begin
        is_byte = (f3[1:0] == 2'b00);
        is_half = (f3[1:0] == 2'b01);
        is_word = (f3[1:0] == 2'b10);

        // Stores only have the signed encodings.
        // Loads also allow LBU/LHU but not an unsigned word.
        if (bus.req_we) begin
            f3_legal = !f3[2] && (f3[1:0] != 2'b11);
        end else begin
            f3_legal = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
        end

        misaligned   = (is_half && bus.req_addr[0]) ||
                       (is_word && (bus.req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, bus.req_addr[31:2]} >= DEPTH_LIMIT);
        req_err      = !f3_legal || misaligned || out_of_range;

        do_sw            = bus.req_we && is_word && !req_err;
        do_subword_store = bus.req_we && !is_word && !req_err;
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits
    always_comb begin
        lane_byte = mem_rdata[7:0];
        case (bus.req_addr[1:0])
            2'b00:   lane_byte = mem_rdata[7:0];
            2'b01:   lane_byte = mem_rdata[15:8];
            2'b10:   lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase

        lane_half = bus.req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (f3[1:0])
            2'b00:   load_data = {{24{lane_byte[7] & ~f3[2]}}, lane_byte};
            2'b01:   load_data = {{16{lane_half[15] & ~f3[2]}}, lane_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Build the write-back word for SB/SH: the current word with one lane replaced
    always_comb begin
        merge_nxt = mem_rdata;
        if (is_byte) begin
            case (bus.req_addr[1:0])
                2'b00:   merge_nxt[7:0]   = bus.req_wdata[7:0];
                2'b01:   merge_nxt[15:8]  = bus.req_wdata[7:0];
                2'b10:   merge_nxt[23:16] = bus.req_wdata[7:0];
                default: merge_nxt[31:24] = bus.req_wdata[7:0];
            endcase
        end else if (bus.req_addr[1]) begin
            merge_nxt[31:16] = bus.req_wdata[15:0];
        end else begin
            merge_nxt[15:0] = bus.req_wdata[15:0];
        end
    end

    // Next-state logic: sub-word stores take the extra write cycle, everything else responds directly
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = do_subword_store ? ST_RMW_WR : ST_RESP;
                end
            end
            ST_RMW_WR: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Memory port mux: the request address/data in IDLE, the latched merge during the write-back
    always_comb begin
        mem_addr  = {bus.req_addr[31:2], 2'b00};
        mem_wdata = bus.req_wdata;
        mem_we    = 1'b0;

        if (state == ST_RMW_WR) begin
            mem_addr  = {rmw_idx, 2'b00};
            mem_wdata = merge_word;
        end

        // Reset kills any write immediately, including a half-finished read-modify-write.
        if (rst_n) begin
            if (state == ST_RMW_WR) begin
                mem_we = 1'b1;
            end else if (state == ST_IDLE && accept && do_sw) begin
                mem_we = 1'b1;
            end
        end
    end

    // State, response registers and read-modify-write latches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            rmw_idx      <= 30'h0;
            merge_word   <= 32'h0;
        end else begin
            state <= state_nxt;

            // Response data only changes on the edge that enters RESP.
            // That keeps the previous response stable until the new one appears.
            if (state == ST_IDLE && accept) begin
                if (req_err) begin
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b1;
                end else if (!bus.req_we) begin
                    resp_rdata_q <= load_data;
                    resp_err_q   <= 1'b0;
                end else if (do_sw) begin
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b0;
                end else begin
                    rmw_idx    <= bus.req_addr[31:2];
                    merge_word <= merge_nxt;
                end
            end else if (state == ST_RMW_WR) begin
                resp_rdata_q <= 32'h0;
                resp_err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/lsu_subword_rmw.md
Name: lsu_subword_rmw

Overview:
Load/store unit between the pipeline MEM stage and the word-only data memory (sync write, combinational read, aligned words only). It adds RV32I byte and halfword access. Loads are lane-selected and sign- or zero-extended. SB/SH are performed as a two-cycle read-modify-write. The unit also flags misaligned, out-of-range and illegal-funct3 accesses, and suppresses the memory access for them.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the downstream data memory; word index >= DEPTH_WORDS is an error.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  MEM stage presents an access
req_ready  out  1  unit accepts the access this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  access faulted (valid with resp_valid)
busy  out  1  state != IDLE (pipeline stall hint)
mem_addr  out  32  word-aligned address to data memory ({word_idx,2'b00})
mem_wdata  out  32  write data to data memory
mem_we  out  1  data memory MemRW (1 = write)
mem_rdata  in  32  data memory dataR (combinational)

Behaviour:
- FSM states: IDLE, RMW_WR, RESP. Reset (rst_n=0 at a clock edge): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, internal latches=0. mem_we is forced 0 combinationally while rst_n=0.
- Legal load funct3 codes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3 codes: 000 SB, 001 SH, 010 SW. Any other code is an error.
- Error condition (evaluated at accept), any of:
  - illegal funct3;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS.
- req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready. Request fields are sampled only in the accept cycle. A request presented outside IDLE is ignored and must be held by the master.
- In IDLE:
  - mem_addr = aligned req_addr.
  - mem_wdata = req_wdata.
  - mem_we=0 unless an SW is accepted.
- Accept, error: no memory write (mem_we=0). Next state RESP with resp_err=1 and resp_rdata=0.
- Accept, load: memory is read in the same cycle. The selected lane is extended and registered into resp_rdata. Next state RESP.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Accept, SW: mem_we=1 and mem_wdata=req_wdata in the accept cycle. Next state RESP.
- Accept, SB/SH: mem_we=0 (read). The merge word is latched with the target lane replaced:
  - SB uses req_wdata[7:0];
  - SH uses req_wdata[15:0].
  - The word address is latched. Next state RMW_WR.
- RMW_WR: mem_addr = latched address, mem_wdata = merge word, mem_we=1. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle; req_ready=0. Next state IDLE. resp_rdata/resp_err hold until the next response.
- Latency from accept edge to resp_valid: load, SW and error take 1 cycle; SB/SH take 2 cycles. Maximum throughput is one access per 2 cycles (per 3 for SB/SH).
- Reset mid-operation:
  - rst_n low during RMW_WR: mem_we=0, no write occurs, the response is dropped and the FSM returns to IDLE.
  - rst_n low during RESP: resp_valid clears at the edge.
- Out-of-range data from memory (read 0) cannot occur because those accesses are flagged as errors first.

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF → accept cycle has mem_we=1, mem_wdata=0xDEADBEEF. Then LW 0x10 → resp_valid 1 cycle after accept, resp_rdata=0xDEADBEEF, resp_err=0.
2. SB addr 0x11, data 0x00000055 on word 0xDEADBEEF → cycle0 mem_we=0; cycle1 mem_we=1, mem_addr=0x10, mem_wdata=0xDEAD55EF; resp_valid at cycle2. A following LW reads 0xDEAD55EF.
3. Loads on word 0xDEAD55EF:
   - LB 0x13 → 0xFFFFFFDE
   - LBU 0x13 → 0x000000DE
   - LH 0x12 → 0xFFFFDEAD
   - LHU 0x12 → 0x0000DEAD
   - LB 0x11 → 0x00000055
4. Error cases (each → resp_err=1, resp_rdata=0, mem_we never asserted, memory unchanged):
   - LW 0x12;
   - SH 0x11;
   - SW 0x1000 with DEPTH_WORDS=1024;
   - funct3=011 load.
5. SH 0x12 data 0x1234 accepted; rst_n=0 during the RMW_WR cycle → mem_we=0, no resp_valid, state IDLE. A subsequent LW 0x10 returns the old word.
6. req_valid held high for a second SB immediately after the first → req_ready=0 and busy=1 in RMW_WR and RESP. The second request is accepted in the next IDLE cycle, 3 cycles after the first accept.
